// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared definitions for the SPI command arbiter: FSM encoding, timeout
// counter width and the position of the read flag inside a frame.
package spi_cmd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_t;

    localparam int TMO_CNT_W = 8;

    // The read flag is always the most significant bit of a frame.
    function automatic int rd_flag_pos(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin grant: the search starts just after the last
// owner and wraps, so the last owner has the lowest priority.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    // First pending requester after 'last', walking upward with wrap-around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(last) + k) % NREQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI master between NREQ requesters. One frame is in flight at a
// time: grant, issue, wait for the master to go busy and idle again, then
// return the captured MISO word (or a timeout error) to the owner.
module spi_cmd_arbiter
    import spi_cmd_arbiter_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = 24,
    parameter  int TIMEOUT = 255,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      spi_data,
    output logic                  spi_ena,
    input  logic                  spi_busy,
    input  logic [WIDTH-1:0]      spi_rx_data,
    input  logic                  spi_rx_ena,
    output logic [IW-1:0]         owner
);

    localparam int RD_BIT = rd_flag_pos(WIDTH);
    // Timeout fires on the cycle the counter would reach TIMEOUT, so a wait
    // state lasts at most TIMEOUT cycles.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    arb_state_t           state_q, state_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [IW-1:0]        owner_q;
    logic [WIDTH-1:0]     frame_q;
    logic [WIDTH-1:0]     rx_q;
    logic                 rd_q;
    logic                 err_q;

    logic [NREQ-1:0]      gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic [WIDTH-1:0]     gnt_frame;
    logic                 accept;
    logic                 capture;
    logic                 tmo_hit;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .last    (owner_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // One-hot mux selecting the granted requester's frame.
    always_comb begin
        gnt_frame = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_frame = gnt_frame | req_data[i*WIDTH +: WIDTH];
        end
    end

    // Next-state, handshake strobes and timeout counter update.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        spi_ena   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld && !spi_busy) begin
                    accept    = 1'b1;
                    req_ready = gnt;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                spi_ena = 1'b1;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                capture = spi_rx_ena && rd_q;
                if (!spi_busy) begin
                    state_d = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < NREQ; i++) rsp_valid[i] = (owner_q == IW'(i));
                rsp_err  = err_q;
                rsp_data = rx_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && (tmo_cnt_q != '1)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // State register and timeout counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Frame context: latched at grant, MISO capture and error flag during the frame.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            owner_q <= IW'(NREQ - 1);
            frame_q <= '0;
            rd_q    <= 1'b0;
            rx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= gnt_idx;
                frame_q <= gnt_frame;
                rd_q    <= gnt_frame[RD_BIT];
                rx_q    <= '0;
                err_q   <= 1'b0;
            end
            if (capture) rx_q  <= spi_rx_data;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign spi_data = frame_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with a small behavioural SPI master.
module tb_spi_cmd_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 24;
    localparam int TIMEOUT = 255;
    localparam int IW      = 2;

    logic                  sys_clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic [WIDTH-1:0]      spi_data;
    logic                  spi_ena;
    logic                  spi_busy;
    logic [WIDTH-1:0]      spi_rx_data;
    logic                  spi_rx_ena;
    logic [IW-1:0]         owner;

    logic [WIDTH-1:0]      slot [NREQ];
    assign req_data = {slot[3], slot[2], slot[1], slot[0]};

    spi_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .spi_data    (spi_data),
        .spi_ena     (spi_ena),
        .spi_busy    (spi_busy),
        .spi_rx_data (spi_rx_data),
        .spi_rx_ena  (spi_rx_ena),
        .owner       (owner)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // SPI master model state (mode 0: model drives busy, mode 1: bench drives busy)
    int               mdl_mode = 0;
    int               bcnt = 0;
    logic [WIDTH-1:0] mdl_rx = '0;
    bit               mdl_no_rx = 1'b0;

    bit               ena_prev = 1'b0;
    int               ena_cnt = 0;
    int               rsp_cnt = 0;
    int               cycle_n = 0;
    int               ena_cyc = 0;
    logic [WIDTH-1:0] ena_data = '0;

    typedef struct {
        logic [1:0]       r;
        logic [WIDTH-1:0] frame;
        logic [WIDTH-1:0] rx;
        bit               no_rx;
        logic [WIDTH-1:0] exp_d;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: update master inputs just after the edge, then sample outputs.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
        if (mdl_mode == 0) begin
            spi_rx_ena = 1'b0;
            if (ena_prev) begin
                spi_busy = 1'b1;
                bcnt     = 30;
            end else if (bcnt > 0) begin
                bcnt--;
                spi_busy   = (bcnt > 0);
                spi_rx_ena = (bcnt == 1) && !mdl_no_rx;
            end
        end
        spi_rx_data = mdl_rx;
        #1;
        cycle_n++;
        if (spi_ena) begin
            check("ena_not_back_to_back", {31'd0, ena_prev}, 32'd0);
            ena_cnt++;
            ena_data = spi_data;
            ena_cyc  = cycle_n;
        end
        if (rsp_valid != '0) rsp_cnt++;
        ena_prev = spi_ena;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                return;
            end
            cyc();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (rsp_valid != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic set_req(input logic [1:0] r, input logic [WIDTH-1:0] f);
        slot[r]      = f;
        req_valid[r] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        check({tag, "_spi_ena"},   {31'd0, spi_ena},   32'd0);
        check({tag, "_rsp_data"},  {8'd0, rsp_data},   32'd0);
        check({tag, "_spi_data"},  {8'd0, spi_data},   32'd0);
        check({tag, "_owner"},     {30'd0, owner},     32'd3);
    endtask

    // Full single-requester frame with the model master answering normally.
    task automatic do_frame(input logic [1:0] r, input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] rx,
                            input bit no_rx, input logic [WIDTH-1:0] exp_d, input string tag);
        bit ok;
        logic [3:0] oh;
        oh        = 4'b0001 << r;
        mdl_mode  = 0;
        mdl_rx    = rx;
        mdl_no_rx = no_rx;
        ena_cnt   = 0;
        set_req(r, f);
        wait_ready(ok);
        check({tag, "_ready_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_req_ready"}, {28'd0, req_ready}, {28'd0, oh});
        cyc();
        req_valid = '0;
        check({tag, "_owner"}, {30'd0, owner}, {30'd0, r});
        wait_rsp(ok);
        check({tag, "_rsp_seen"},  {31'd0, ok},        32'd1);
        check({tag, "_rsp_valid"}, {28'd0, rsp_valid}, {28'd0, oh});
        check({tag, "_rsp_data"},  {8'd0, rsp_data},   {8'd0, exp_d});
        check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        check({tag, "_ena_count"}, ena_cnt,            32'd1);
        check({tag, "_spi_data"},  {8'd0, ena_data},   {8'd0, f});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int rdy;
        logic [1:0] e;
        logic [3:0] oh;

        vt[0] = '{2'd0, 24'h012345, 24'h5A5A5A, 1'b0, 24'h000000};
        vt[1] = '{2'd2, 24'h812300, 24'h0000AB, 1'b0, 24'h0000AB};
        vt[2] = '{2'd1, 24'hFFFFFF, 24'h123456, 1'b0, 24'h123456};
        vt[3] = '{2'd3, 24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h000000};
        vt[4] = '{2'd0, 24'h800000, 24'h777777, 1'b1, 24'h000000};
        vt[5] = '{2'd3, 24'hC0FFEE, 24'hABCDEF, 1'b0, 24'hABCDEF};

        req_valid   = '0;
        for (int i = 0; i < NREQ; i++) slot[i] = '0;
        spi_busy    = 1'b0;
        spi_rx_ena  = 1'b0;
        spi_rx_data = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            do_frame(vt[v].r, vt[v].frame, vt[v].rx, vt[v].no_rx, vt[v].exp_d, $sformatf("vec%0d", v));
        end

        // Fairness with all requesters held high from reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mdl_mode  = 0;
        mdl_no_rx = 1'b0;
        for (int i = 0; i < NREQ; i++) slot[i] = 24'hA00000 | 24'(i);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            e  = 2'(k);
            oh = 4'b0001 << e;
            wait_ready(ok);
            check($sformatf("fair%0d_ready_seen", k), {31'd0, ok}, 32'd1);
            check($sformatf("fair%0d_grant", k), {28'd0, req_ready}, {28'd0, oh});
            cyc();
            wait_rsp(ok);
            check($sformatf("fair%0d_rsp_valid", k), {28'd0, rsp_valid}, {28'd0, oh});
        end
        req_valid = '0;

        // Master busy while idle: nothing granted until busy drops
        mdl_mode   = 1;
        spi_busy   = 1'b1;
        spi_rx_ena = 1'b0;
        set_req(2'd1, 24'h0ABCDE);
        rdy = 0;
        repeat (20) begin
            cyc();
            if (req_ready != '0) rdy++;
        end
        check("busy_idle_no_ready", rdy, 32'd0);
        spi_busy = 1'b0;
        mdl_mode = 0;
        #1;
        check("busy_idle_ready_after_drop", {28'd0, req_ready}, 32'h2);
        cyc();
        req_valid = '0;
        wait_rsp(ok);
        check("busy_idle_rsp_valid", {28'd0, rsp_valid}, 32'h2);

        // Timeout in WAIT_BUSY: master never asserts busy
        mdl_mode   = 1;
        spi_busy   = 1'b0;
        spi_rx_ena = 1'b0;
        ena_cnt    = 0;
        set_req(2'd1, 24'h055555);
        wait_ready(ok);
        check("tmo_ready_seen", {31'd0, ok}, 32'd1);
        cyc();
        req_valid = '0;
        wait_rsp(ok);
        check("tmo_rsp_seen",  {31'd0, ok},        32'd1);
        check("tmo_rsp_valid", {28'd0, rsp_valid}, 32'h2);
        check("tmo_rsp_err",   {31'd0, rsp_err},   32'd1);
        check("tmo_rsp_data",  {8'd0, rsp_data},   32'd0);
        check("tmo_latency",   cycle_n - ena_cyc,  32'd256);
        check("tmo_ena_count", ena_cnt,            32'd1);
        set_req(2'd2, 24'h812345);
        cyc();
        check("tmo_back_to_idle_grant", {28'd0, req_ready}, 32'h4);
        mdl_mode  = 0;
        mdl_rx    = 24'h00FACE;
        mdl_no_rx = 1'b0;
        cyc();
        req_valid = '0;
        wait_rsp(ok);
        check("after_tmo_rsp_valid", {28'd0, rsp_valid}, 32'h4);
        check("after_tmo_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("after_tmo_rsp_data",  {8'd0, rsp_data},   32'h00FACE);

        // Reset while the master is busy with a read
        mdl_mode = 0;
        mdl_rx   = 24'h111111;
        set_req(2'd3, 24'h8F0F0F);
        wait_ready(ok);
        check("rstmid_ready_seen", {31'd0, ok}, 32'd1);
        cyc();
        req_valid = '0;
        repeat (10) cyc();
        check("rstmid_master_busy", {31'd0, spi_busy}, 32'd1);
        rst = 1'b1;
        cyc();
        check_reset_outputs("rstmid");
        rst     = 1'b0;
        rsp_cnt = 0;
        repeat (40) cyc();
        check("rstmid_no_rsp", rsp_cnt, 32'd0);
        do_frame(2'd1, 24'h123456, 24'h000000, 1'b0, 24'h000000, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
